prog_delay_line: RTL

PROG_DELAY_LINE -- requirements
Module: prog_delay_line

---
 rtl/prog_delay_line.sv | 81 ++++++++
 1 files changed

// File: rtl/prog_delay_line.sv
// Programmable sample delay line: a tap shift register advanced on each sample strobe.
// The output tap is chosen by cur_delay; a new delay is staged and takes effect at a strobe.
module prog_delay_line #(
  parameter int WIDTH         = 18,
  parameter int MAX_DELAY     = 20,
  parameter int DEFAULT_DELAY = 10,
  parameter int DW            = 5
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic signed [WIDTH-1:0] sig_in,
  input  logic [DW-1:0]           delay_req,
  input  logic                    delay_load,
  output logic signed [WIDTH-1:0] sig_out,
  output logic                    out_valid,
  output logic                    delay_busy,
  output logic [DW-1:0]           cur_delay,
  output logic                    range_err
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
  localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

  logic signed [WIDTH-1:0] taps [MAX_DELAY];
  logic signed [WIDTH-1:0] tap_sel;
  logic [DW-1:0]           fill_cnt;
  logic [DW-1:0]           pending;
  logic [DW-1:0]           req_clamped;

  assign req_clamped = (delay_req > MAX_D) ? MAX_D : delay_req;

  // Delay 0 bypasses the taps; otherwise read the pre-shift tap cur_delay-1.
  always_comb begin
    tap_sel = sig_in;
    for (int k = 0; k < MAX_DELAY; k++)
      if (cur_delay == DW'(k + 1)) tap_sel = taps[k];
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int k = 0; k < MAX_DELAY; k++) taps[k] <= '0;
    end else if (sam_clk_en) begin
      taps[0] <= sig_in;
      for (int k = 1; k < MAX_DELAY; k++) taps[k] <= taps[k-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sig_out   <= '0;
      out_valid <= 1'b0;
      fill_cnt  <= '0;
    end else if (sam_clk_en) begin
      sig_out   <= tap_sel;
      out_valid <= (fill_cnt >= cur_delay);
      if (fill_cnt != MAX_D) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // A strobe consumes the older pending request; a coincident load re-arms busy afterwards.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cur_delay  <= DEF_D;
      pending    <= '0;
      delay_busy <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      if (sam_clk_en && delay_busy) begin
        cur_delay  <= pending;
        delay_busy <= 1'b0;
      end
      if (delay_load) begin
        pending    <= req_clamped;
        delay_busy <= 1'b1;
        if (delay_req > MAX_D) range_err <= 1'b1;
      end
    end
  end

endmodule
